// File: rtl/jpeg_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Package : jpeg_enc_pkg
//  Shared byte type, stuffing constants and FSM encoding for the JPEG
//  entropy-coded-segment byte stuffer.
//  Revision: 1.0 - initial release
// ============================================================================
package jpeg_enc_pkg;

    typedef logic [7:0] byte_t;

    // A marker-prefix byte inside entropy-coded data must be followed by a
    // zero byte so that decoders do not mistake it for a marker.
    localparam byte_t MARKER_BYTE = 8'hFF;
    localparam byte_t STUFF_BYTE  = 8'h00;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } stuff_state_e;

endpackage : jpeg_enc_pkg
`default_nettype wire

// File: rtl/jpeg_ff_stuffer_ff_expand.sv
`default_nettype none
// ============================================================================
//  Module  : ff_expand
//  Combinational byte stuffer for one 32-bit word. Bytes are taken MSB-first;
//  every 0xFF byte is followed by an inserted 0x00.
//  Ports   : word      - input word, [31:24] is the first byte
//            exp_bytes - expanded bytes in stream order, index 0 first
//            count     - number of valid expanded bytes (4..8)
//            ff_cnt    - number of stuff bytes inserted (0..4)
//  Revision: 1.0 - initial release
// ============================================================================
module ff_expand
    import jpeg_enc_pkg::*;
(
    input  logic [31:0] word,
    output byte_t       exp_bytes [8],
    output logic [3:0]  count,
    output logic [2:0]  ff_cnt
);

    logic [3:0] w_pos;
    byte_t      w_b;

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            exp_bytes[j] = STUFF_BYTE;
        end
        w_pos  = '0;
        ff_cnt = '0;
        w_b    = '0;
        for (int k = 0; k < 4; k++) begin
            w_b = word[8*(3-k) +: 8];
            exp_bytes[w_pos[2:0]] = w_b;
            w_pos = w_pos + 4'd1;
            if (w_b == MARKER_BYTE) begin
                exp_bytes[w_pos[2:0]] = STUFF_BYTE;
                w_pos  = w_pos + 4'd1;
                ff_cnt = ff_cnt + 3'd1;
            end
        end
        count = w_pos;
    end

endmodule : ff_expand
`default_nettype wire

// File: rtl/jpeg_ff_stuffer.sv
`default_nettype none
// ============================================================================
//  Module  : jpeg_ff_stuffer
//  Pops 32-bit encoded words from a FIFO, inserts 0x00 after every 0xFF byte
//  and repacks the resulting byte stream into 32-bit output words. The last,
//  possibly partial, word of a scan is flagged with out_last/out_bytes.
//  Ports   : clk, rst (async, active-low)
//            fifo_empty, read_req, read_data, rdata_valid - FIFO read side
//            eof_in      - pulse: last word of the scan is in the FIFO
//            out_data/out_valid/out_ready/out_last/out_bytes - output stream
//            stuff_count - 0x00 bytes inserted in this scan (saturating)
//  Revision: 1.0 - initial release
// ============================================================================
module jpeg_ff_stuffer
    import jpeg_enc_pkg::*;
#(
    parameter int BUF_BYTES = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [31:0]      read_data,
    input  logic             rdata_valid,
    output logic             read_req,
    input  logic             eof_in,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [2:0]       out_bytes,
    output logic [CNT_W-1:0] stuff_count
);

    localparam int c_occ_w = $clog2(BUF_BYTES + 1);
    localparam int c_idx_w = $clog2(BUF_BYTES);
    localparam logic [c_occ_w-1:0] c_four       = c_occ_w'(4);
    localparam logic [c_occ_w:0]   c_word_max   = (c_occ_w+1)'(8);
    localparam logic [c_occ_w:0]   c_credit_lim = (c_occ_w+1)'(BUF_BYTES - 8);

    stuff_state_e      r_state;
    stuff_state_e      w_state_nxt;
    byte_t             r_buf     [BUF_BYTES];
    byte_t             w_buf_nxt [BUF_BYTES];
    logic [c_occ_w-1:0] r_occ;
    logic [c_occ_w-1:0] w_occ_nxt;
    logic [c_occ_w-1:0] w_base;
    logic               r_inflight;
    logic               r_eof;
    logic [CNT_W-1:0]   r_stuff_count;
    logic [CNT_W:0]     w_cnt_sum;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [c_occ_w:0]   w_credit_sum;

    byte_t      w_exp [8];
    logic [3:0] w_exp_cnt;
    logic [2:0] w_ff_cnt;

    logic       w_run;
    logic       w_flush;
    logic       w_push;
    logic       w_fire;
    logic [2:0] w_pop;
    logic       w_go_flush;

    ff_expand u_expand (
        .word      (read_data),
        .exp_bytes (w_exp),
        .count     (w_exp_cnt),
        .ff_cnt    (w_ff_cnt)
    );

    assign w_run   = (r_state == RUN);
    assign w_flush = (r_state == FLUSH);

    // Credit check counts a word still in flight as a full 8-byte worst case.
    // Gated by rst so the request is low while reset is asserted.
    assign w_credit_sum = {1'b0, r_occ} + (r_inflight ? c_word_max : '0);
    assign read_req     = rst && w_run && !fifo_empty && (w_credit_sum <= c_credit_lim);

    // Only data answering our own request is taken; a word requested before
    // a reset finds r_inflight cleared and is dropped.
    assign w_push = w_run && rdata_valid && r_inflight;

    assign out_valid = w_run ? (r_occ >= c_four) : (w_flush && (r_occ != '0));
    assign w_fire    = out_valid && out_ready;
    assign w_pop     = !w_fire ? 3'd0 : ((r_occ >= c_four) ? 3'd4 : r_occ[2:0]);
    assign out_data  = {r_buf[0], r_buf[1], r_buf[2], r_buf[3]};
    assign out_last  = w_flush && (r_occ != '0) && (r_occ <= c_four);
    assign out_bytes = !out_valid ? 3'd0 : ((r_occ >= c_four) ? 3'd4 : r_occ[2:0]);
    assign stuff_count = r_stuff_count;

    assign w_base    = r_occ - c_occ_w'(w_pop);
    assign w_occ_nxt = w_base + (w_push ? c_occ_w'(w_exp_cnt) : '0);

    assign w_cnt_sum = {1'b0, r_stuff_count} + (CNT_W+1)'(w_ff_cnt);
    assign w_cnt_nxt = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];

    assign w_go_flush = r_eof && fifo_empty && !r_inflight && !rdata_valid;

    // Bytes beyond the occupancy are kept at zero: shifting pulls zeros in
    // from the tail and appends write only valid positions, which gives the
    // zero-filled partial words for free.
    always_comb begin
        for (int i = 0; i < BUF_BYTES; i++) begin
            w_buf_nxt[i] = STUFF_BYTE;
            if (i + int'(w_pop) < BUF_BYTES) begin
                w_buf_nxt[i] = r_buf[c_idx_w'(i + int'(w_pop))];
            end
        end
        if (w_push) begin
            for (int j = 0; j < 8; j++) begin
                if ((j < int'(w_exp_cnt)) && (int'(w_base) + j < BUF_BYTES)) begin
                    w_buf_nxt[c_idx_w'(int'(w_base) + j)] = w_exp[j];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_go_flush) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Leave once the buffer is empty or its final word is taken.
                if (r_occ == '0) begin
                    w_state_nxt = DONE;
                end else if (w_fire && (r_occ <= c_four)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= RUN;
            r_occ         <= '0;
            r_inflight    <= 1'b0;
            r_eof         <= 1'b0;
            r_stuff_count <= '0;
            r_buf         <= '{default: STUFF_BYTE};
        end else begin
            r_state    <= w_state_nxt;
            r_occ      <= w_occ_nxt;
            r_inflight <= read_req;
            r_buf      <= w_buf_nxt;
            if (r_state == DONE) begin
                r_eof         <= 1'b0;
                r_stuff_count <= '0;
            end else begin
                if (eof_in && w_run) begin
                    r_eof <= 1'b1;
                end
                if (w_push) begin
                    r_stuff_count <= w_cnt_nxt;
                end
            end
        end
    end

endmodule : jpeg_ff_stuffer
`default_nettype wire

// File: tb/tb_jpeg_ff_stuffer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_jpeg_ff_stuffer
//  Directed and random bench for jpeg_ff_stuffer with a FIFO read model
//  (data one cycle after read_req) and an output word collector.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_jpeg_ff_stuffer;
    import jpeg_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] read_data = '0;
    logic        rdata_valid = 1'b0;
    logic        read_req;
    logic        eof_in = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [2:0]  out_bytes;
    logic [15:0] stuff_count;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [2:0]  nbytes;
    } rec_t;

    logic [31:0] fifo_q [$];
    rec_t        out_q  [$];
    logic        pending = 1'b0;
    logic [31:0] pend_word = '0;
    int          n_total = 0;
    int          n_bad = 0;
    int          max_occ = 0;
    int          proto_err = 0;

    jpeg_ff_stuffer #(.BUF_BYTES(16), .CNT_W(16)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .read_data   (read_data),
        .rdata_valid (rdata_valid),
        .read_req    (read_req),
        .eof_in      (eof_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_bytes   (out_bytes),
        .stuff_count (stuff_count)
    );

    always #5 clk = ~clk;

    // FIFO flag follows the queue a little after each rising edge.
    always @(posedge clk) begin
        #2;
        fifo_empty = (fifo_q.size() == 0);
    end

    // Mid-cycle: record transfers, answer last cycle's request, take a new one.
    always @(negedge clk) begin
        if (!rst) begin
            pending     = 1'b0;
            rdata_valid = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_q.push_back('{data: out_data, last: out_last, nbytes: out_bytes});
            end
            if (int'(u_dut.r_occ) > max_occ) max_occ = int'(u_dut.r_occ);
            if (rdata_valid && (u_dut.r_state != RUN)) proto_err++;
            rdata_valid = pending;
            read_data   = pend_word;
            pending     = 1'b0;
            if (read_req && (fifo_q.size() > 0)) begin
                pending   = 1'b1;
                pend_word = fifo_q.pop_front();
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_eof();
        eof_in = 1'b1;
        tick(1);
        eof_in = 1'b0;
    endtask

    task automatic wait_outs(input int n, input int budget, input string name);
        int c;
        c = 0;
        while ((out_q.size() < n) && (c < budget)) begin
            tick(1);
            c++;
        end
        n_total++;
        if (out_q.size() < n) begin
            n_bad++;
            $display("FAIL %s timeout: got %0d words, need %0d", name, out_q.size(), n);
        end
    endtask

    task automatic test_reset();
        fifo_q.push_back(32'h12345678);
        tick(3);
        n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", out_valid); end
        n_total++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", out_data); end
        n_total++; if ({out_last, out_bytes} !== 4'h0) begin n_bad++; $display("FAIL rst_last_bytes got %b/%0d want 0/0", out_last, out_bytes); end
        n_total++; if (stuff_count !== 16'h0) begin n_bad++; $display("FAIL rst_count got %0d want 0", stuff_count); end
        n_total++; if (read_req !== 1'b0) begin n_bad++; $display("FAIL rst_read_req got %b want 0", read_req); end
        rst = 1'b1;
    endtask

    task automatic test_plain();
        rec_t r;
        out_ready = 1'b1;
        wait_outs(1, 20, "plain");
        if (out_q.size() > 0) begin
            r = out_q.pop_front();
            n_total++; if (r.data !== 32'h12345678 || r.nbytes !== 3'd4 || r.last !== 1'b0) begin
                n_bad++; $display("FAIL plain_word got %h/%0d/%b want 12345678/4/0", r.data, r.nbytes, r.last);
            end
        end
        tick(2);
        n_total++; if (stuff_count !== 16'd0) begin n_bad++; $display("FAIL plain_count got %0d want 0", stuff_count); end
    endtask

    task automatic test_ff_mix();
        rec_t r;
        out_q.delete();
        out_ready = 1'b1;
        fifo_q.push_back(32'hFF00FF11);
        fifo_q.push_back(32'h22334455);
        wait_outs(2, 30, "ffmix");
        if (out_q.size() >= 2) begin
            r = out_q.pop_front();
            n_total++; if (r.data !== 32'hFF0000FF) begin n_bad++; $display("FAIL ffmix_w0 got %h want ff0000ff", r.data); end
            r = out_q.pop_front();
            n_total++; if (r.data !== 32'h00112233) begin n_bad++; $display("FAIL ffmix_w1 got %h want 00112233", r.data); end
        end
        tick(3);
        n_total++; if (stuff_count !== 16'd2) begin n_bad++; $display("FAIL ffmix_count got %0d want 2", stuff_count); end
        n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ffmix_hold2 got valid %b want 0", out_valid); end
        pulse_eof();
        wait_outs(1, 30, "ffmix_tail");
        if (out_q.size() > 0) begin
            r = out_q.pop_front();
            n_total++; if (r.data !== 32'h44550000 || r.last !== 1'b1 || r.nbytes !== 3'd2) begin
                n_bad++; $display("FAIL ffmix_tail got %h/%b/%0d want 44550000/1/2", r.data, r.last, r.nbytes);
            end
        end
        tick(3);
        n_total++; if (stuff_count !== 16'd0) begin n_bad++; $display("FAIL ffmix_count_clr got %0d want 0", stuff_count); end
    endtask

    task automatic test_backpressure();
        rec_t r;
        out_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hFFFFFFFF);
        tick(12);
        n_total++; if (fifo_q.size() != 2) begin n_bad++; $display("FAIL bp_fifo_left got %0d want 2", fifo_q.size()); end
        n_total++; if (read_req !== 1'b0) begin n_bad++; $display("FAIL bp_read_req got %b want 0", read_req); end
        n_total++; if (out_valid !== 1'b1 || out_data !== 32'hFF00FF00) begin
            n_bad++; $display("FAIL bp_hold got %b/%h want 1/ff00ff00", out_valid, out_data);
        end
        out_ready = 1'b1;
        wait_outs(8, 80, "bp_drain");
        for (int i = 0; i < 8; i++) begin
            if (out_q.size() > 0) begin
                r = out_q.pop_front();
                n_total++; if (r.data !== 32'hFF00FF00 || r.last !== 1'b0) begin
                    n_bad++; $display("FAIL bp_word%0d got %h/%b want ff00ff00/0", i, r.data, r.last);
                end
            end
        end
        n_total++; if (stuff_count !== 16'd16) begin n_bad++; $display("FAIL bp_count got %0d want 16", stuff_count); end
        // Scan ends with nothing buffered: no final word may appear.
        pulse_eof();
        tick(10);
        n_total++; if (out_q.size() != 0) begin n_bad++; $display("FAIL empty_flush got %0d words want 0", out_q.size()); end
        n_total++; if (stuff_count !== 16'd0) begin n_bad++; $display("FAIL empty_flush_count got %0d want 0", stuff_count); end
    endtask

    task automatic test_eof();
        rec_t r;
        out_q.delete();
        out_ready = 1'b0;
        fifo_q.push_back(32'hAABBCCDD);
        fifo_q.push_back(32'h11223344);
        pulse_eof();
        tick(10);
        out_ready = 1'b1;
        wait_outs(2, 30, "eof4");
        if (out_q.size() >= 2) begin
            r = out_q.pop_front();
            n_total++; if (r.data !== 32'hAABBCCDD || r.last !== 1'b0 || r.nbytes !== 3'd4) begin
                n_bad++; $display("FAIL eof4_w0 got %h/%b/%0d want aabbccdd/0/4", r.data, r.last, r.nbytes);
            end
            r = out_q.pop_front();
            n_total++; if (r.data !== 32'h11223344 || r.last !== 1'b1 || r.nbytes !== 3'd4) begin
                n_bad++; $display("FAIL eof4_w1 got %h/%b/%0d want 11223344/1/4", r.data, r.last, r.nbytes);
            end
        end
        tick(3);
        out_ready = 1'b0;
        fifo_q.push_back(32'hFFFFEEFF);
        pulse_eof();
        tick(10);
        n_total++; if (stuff_count !== 16'd3) begin n_bad++; $display("FAIL eof3_count got %0d want 3", stuff_count); end
        out_ready = 1'b1;
        wait_outs(2, 30, "eof3");
        if (out_q.size() >= 2) begin
            r = out_q.pop_front();
            n_total++; if (r.data !== 32'hFF00FF00 || r.last !== 1'b0) begin
                n_bad++; $display("FAIL eof3_w0 got %h/%b want ff00ff00/0", r.data, r.last);
            end
            r = out_q.pop_front();
            n_total++; if (r.data !== 32'hEEFF0000 || r.last !== 1'b1 || r.nbytes !== 3'd3) begin
                n_bad++; $display("FAIL eof3_w1 got %h/%b/%0d want eeff0000/1/3", r.data, r.last, r.nbytes);
            end
        end
        tick(3);
    endtask

    task automatic test_reset_mid();
        rec_t r;
        out_q.delete();
        out_ready = 1'b0;
        fifo_q.push_back(32'hFF11FF22);
        tick(6);
        n_total++; if (out_valid !== 1'b1 || out_data !== 32'hFF0011FF) begin
            n_bad++; $display("FAIL mid_pre got %b/%h want 1/ff0011ff", out_valid, out_data);
        end
        #3;
        rst = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || stuff_count !== 16'h0 || out_bytes !== 3'd0) begin
            n_bad++; $display("FAIL mid_async got %b/%h/%0d/%0d want 0/0/0/0", out_valid, out_data, stuff_count, out_bytes);
        end
        tick(2);
        rst = 1'b1;
        out_ready = 1'b1;
        fifo_q.push_back(32'h0BADBEEF);
        wait_outs(1, 20, "mid_post");
        if (out_q.size() > 0) begin
            r = out_q.pop_front();
            n_total++; if (r.data !== 32'h0BADBEEF || r.nbytes !== 3'd4) begin
                n_bad++; $display("FAIL mid_post got %h/%0d want 0badbeef/4", r.data, r.nbytes);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  gold [$];
        logic [7:0]  got  [$];
        logic [31:0] w;
        logic [7:0]  b;
        int          ffs;
        int          c;
        int          errs;
        int          first_bad;
        int          nlast;
        int          bad_ff;
        rec_t        r;
        out_q.delete();
        ffs = 0;
        for (int i = 0; i < 1000; i++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                b = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
                w = {w[23:0], b};
                gold.push_back(b);
                if (b == 8'hFF) begin
                    gold.push_back(8'h00);
                    ffs++;
                end
            end
            fifo_q.push_back(w);
        end
        c = 0;
        while (((fifo_q.size() > 0) || pending || rdata_valid) && (c < 20000)) begin
            out_ready = ($urandom_range(9) < 6);
            tick(1);
            c++;
        end
        tick(3);
        n_total++; if (int'(stuff_count) != ffs) begin n_bad++; $display("FAIL rnd_count got %0d want %0d", stuff_count, ffs); end
        pulse_eof();
        c = 0;
        nlast = 0;
        while ((c < 20000) && !((out_q.size() > 0) && out_q[out_q.size()-1].last)) begin
            out_ready = ($urandom_range(9) < 6);
            tick(1);
            c++;
        end
        out_ready = 1'b1;
        while (out_q.size() > 0) begin
            r = out_q.pop_front();
            if (r.last) nlast++;
            for (int k = 0; k < int'(r.nbytes); k++) got.push_back(r.data[8*(3-k) +: 8]);
        end
        n_total++; if (nlast != 1) begin n_bad++; $display("FAIL rnd_last got %0d last words want 1", nlast); end
        n_total++; if (got.size() != gold.size()) begin n_bad++; $display("FAIL rnd_len got %0d bytes want %0d", got.size(), gold.size()); end
        errs = 0;
        first_bad = -1;
        for (int i = 0; i < gold.size() && i < got.size(); i++) begin
            if (got[i] !== gold[i]) begin
                errs++;
                if (first_bad < 0) first_bad = i;
            end
        end
        n_total++; if (errs != 0) begin n_bad++; $display("FAIL rnd_stream got %0d byte errors (first at %0d) want 0", errs, first_bad); end
        bad_ff = 0;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] == 8'hFF) begin
                if ((i + 1 >= got.size()) || (got[i+1] != 8'h00)) bad_ff++;
                i++;
            end
        end
        n_total++; if (bad_ff != 0) begin n_bad++; $display("FAIL rnd_ff_follow got %0d unstuffed FF want 0", bad_ff); end
        tick(3);
    endtask

    initial begin
        test_reset();
        test_plain();
        test_ff_mix();
        test_backpressure();
        test_eof();
        test_reset_mid();
        test_random();
        n_total++; if (max_occ > 16) begin n_bad++; $display("FAIL occ_bound got %0d want <=16", max_occ); end
        n_total++; if (proto_err != 0) begin n_bad++; $display("FAIL rdata_not_run got %0d want 0", proto_err); end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_jpeg_ff_stuffer
`default_nettype wire
